// File: rtl/axis_ins_pkg.sv
`default_nettype none
// ============================================================================
// Package     : axis_ins_pkg
// Description : Shared types and helpers for the AXI-Stream header inserter:
//               FSM state encoding, byte-mask builders and a popcount.
//               Masks are built at MAX_BYTES width; callers take the low
//               DATA_BYTE_WD bits.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_ins_pkg;

  localparam int MAX_BYTES = 64;

  typedef logic [MAX_BYTES-1:0] bmask_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  // n ones starting at bit 0
  function automatic bmask_t lsb_mask(input int n);
    bmask_t m;
    m = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

  // n ones ending at bit w-1 (top of a w-bit field)
  function automatic bmask_t msb_mask(input int n, input int w);
    bmask_t m;
    m = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if ((i < w) && (i >= w - n)) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic int popcount(input bmask_t v);
    int c;
    c = 0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (v[i]) c = c + 1;
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_hdr_merge.sv
`default_nettype none
// ============================================================================
// Module      : axis_hdr_merge
// Description : Combinational byte realigner. Builds the output word from the
//               H-byte residue and the top N-H bytes of the incoming word, and
//               extracts the low H bytes of the incoming word as next residue.
// Ports       : i_res      residue, valid bytes in the LSBs
//               i_data     incoming word (byte N-1 first on the wire)
//               i_h        residue length in bytes, 0..N
//               o_merged   {residue, top N-H bytes of i_data}
//               o_res_next low H bytes of i_data, upper bytes zeroed
// Revision    : 1.0 - initial release
// ============================================================================
module axis_hdr_merge
  import axis_ins_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic [DATA_WD-1:0]     i_res,
  input  logic [DATA_WD-1:0]     i_data,
  input  logic [BYTE_CNT_WD-1:0] i_h,
  output logic [DATA_WD-1:0]     o_merged,
  output logic [DATA_WD-1:0]     o_res_next
);

  int           w_sh_res;
  int           w_sh_dat;
  bmask_t       w_lmask;
  logic [DATA_WD-1:0] w_bmask;

  // Shifting by the full width yields zero, which covers H=0 and H=N.
  always_comb begin
    w_sh_res = 8 * (DATA_BYTE_WD - int'(i_h));
    w_sh_dat = 8 * int'(i_h);
    o_merged = (i_res << w_sh_res) | (i_data >> w_sh_dat);
  end

  assign w_lmask = lsb_mask(int'(i_h));

  for (genvar gi = 0; gi < DATA_BYTE_WD; gi++) begin : g_bytes
    assign w_bmask[8*gi +: 8] = {8{w_lmask[gi]}};
  end

  assign o_res_next = i_data & w_bmask;

  if (DATA_BYTE_WD < MAX_BYTES) begin : g_unused
    logic w_unused;
    assign w_unused = |w_lmask[MAX_BYTES-1:DATA_BYTE_WD];
  end

endmodule
`default_nettype wire

// File: rtl/axis_insert_header_pipe.sv
`default_nettype none
// ============================================================================
// Module      : axis_insert_header_pipe
// Description : AXI-Stream header inserter with registered output. Prepends a
//               0..N byte header to each packet, realigns payload bytes and
//               emits an extra tail beat when the packet overflows.
// Ports       : clk/rst           clock, async active-high reset
//               *_in              payload slave stream
//               *_out             registered master stream, full backpressure
//               *_insert          header slave (data in LSBs, H bytes)
//               byte_insert_cnt   header length H (clamped to N)
//               data_word_cnt     output beats handshaken in current packet
//               hdr_err           sticky header keep/length mismatch
// Revision    : 1.0 - initial release
// ============================================================================
module axis_insert_header_pipe
  import axis_ins_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1,
  parameter int CNT_WD       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
  output logic                    ready_insert,
  output logic [CNT_WD-1:0]       data_word_cnt,
  output logic                    hdr_err
);

  localparam logic [BYTE_CNT_WD-1:0] C_N = BYTE_CNT_WD'(DATA_BYTE_WD);

  state_t                  r_state, w_next;
  logic [BYTE_CNT_WD-1:0]  r_h;
  logic [DATA_WD-1:0]      r_res;
  logic [DATA_BYTE_WD-1:0] r_fkeep;
  logic                    r_valid, r_last, r_err;
  logic [DATA_WD-1:0]      r_data;
  logic [DATA_BYTE_WD-1:0] r_keep;
  logic [CNT_WD-1:0]       r_cnt;

  logic                    w_slot_free, w_hdr_acc, w_beat_acc, w_need_flush;
  logic [BYTE_CNT_WD-1:0]  w_h_cl, w_m_h;
  logic [DATA_WD-1:0]      w_m_data, w_merged, w_res_next, w_kexp, w_o_data;
  int                      w_l, w_sum;
  bmask_t                  w_kfull, w_lmask;
  logic                    w_load, w_o_last;
  logic [DATA_BYTE_WD-1:0] w_o_keep;

  assign w_slot_free  = !r_valid || ready_out;
  assign w_hdr_acc    = valid_insert && ready_insert;
  assign w_beat_acc   = valid_in && ready_in;
  assign w_h_cl       = (byte_insert_cnt > C_N) ? C_N : byte_insert_cnt;
  assign w_l          = popcount(bmask_t'(keep_in));
  assign w_sum        = int'(r_h) + w_l;
  assign w_need_flush = w_sum > DATA_BYTE_WD;
  // One mask serves both the in-place last beat and the later tail beat.
  assign w_kfull      = msb_mask(w_need_flush ? (w_sum - DATA_BYTE_WD) : w_sum, DATA_BYTE_WD);
  assign w_lmask      = lsb_mask(int'(w_h_cl));

  // The merger is shared: header load in IDLE, payload in STREAM, and in
  // FLUSH a zero word so the output is the residue alone.
  assign w_m_data = (r_state == IDLE)   ? data_insert :
                    (r_state == STREAM) ? data_in : '0;
  assign w_m_h    = (r_state == IDLE)   ? w_h_cl : r_h;

  axis_hdr_merge #(
    .DATA_WD      (DATA_WD),
    .DATA_BYTE_WD (DATA_BYTE_WD),
    .BYTE_CNT_WD  (BYTE_CNT_WD)
  ) u_merge (
    .i_res      (r_res),
    .i_data     (w_m_data),
    .i_h        (w_m_h),
    .o_merged   (w_merged),
    .o_res_next (w_res_next)
  );

  // FSM next state and handshake readies
  always_comb begin
    w_next       = r_state;
    ready_in     = 1'b0;
    ready_insert = 1'b0;
    case (r_state)
      IDLE: begin
        ready_insert = !rst;
        if (valid_insert && !rst) w_next = STREAM;
      end
      STREAM: begin
        ready_in = w_slot_free;
        if (valid_in && w_slot_free && last_in) w_next = w_need_flush ? FLUSH : IDLE;
      end
      FLUSH: begin
        if (w_slot_free) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Next output beat; invalid lanes of a last beat are zeroed.
  always_comb begin
    w_load   = 1'b0;
    w_o_keep = '1;
    w_o_last = 1'b0;
    if (w_beat_acc) begin
      w_load = 1'b1;
      if (last_in && !w_need_flush) begin
        w_o_keep = w_kfull[DATA_BYTE_WD-1:0];
        w_o_last = 1'b1;
      end
    end else if (r_state == FLUSH) begin
      w_load   = 1'b1;
      w_o_keep = r_fkeep;
      w_o_last = 1'b1;
    end
  end

  for (genvar gi = 0; gi < DATA_BYTE_WD; gi++) begin : g_kexp
    assign w_kexp[8*gi +: 8] = {8{w_o_keep[gi]}};
  end

  assign w_o_data = w_merged & w_kexp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h     <= '0;
      r_res   <= '0;
      r_fkeep <= '0;
    end else begin
      if (w_hdr_acc) begin
        r_h   <= w_h_cl;
        r_res <= w_res_next;
      end
      if (w_beat_acc) begin
        r_res <= w_res_next;
        if (last_in && w_need_flush) r_fkeep <= w_kfull[DATA_BYTE_WD-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
    end else if (w_slot_free) begin
      r_valid <= w_load;
      if (w_load) begin
        r_data <= w_o_data;
        r_keep <= w_o_keep;
        r_last <= w_o_last;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_hdr_acc) begin
        r_cnt <= '0;
        if (keep_insert != w_lmask[DATA_BYTE_WD-1:0]) r_err <= 1'b1;
      end else if (r_valid && ready_out && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_WD'(1);
      end
    end
  end

  assign valid_out     = r_valid;
  assign data_out      = r_data;
  assign keep_out      = r_keep;
  assign last_out      = r_last;
  assign data_word_cnt = r_cnt;
  assign hdr_err       = r_err;

  if (DATA_BYTE_WD < MAX_BYTES) begin : g_unused
    logic w_unused;
    assign w_unused = |{w_kfull[MAX_BYTES-1:DATA_BYTE_WD], w_lmask[MAX_BYTES-1:DATA_BYTE_WD]};
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_insert_header_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_insert_header_pipe
// Description : Directed bench for axis_insert_header_pipe (DATA_WD=32).
//               A byte-level packet model fills a scoreboard queue as each
//               packet is driven; a negedge monitor pops and compares every
//               output handshake and checks stability while stalled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_insert_header_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, last_in, ready_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        valid_out, last_out, ready_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        valid_insert, ready_insert;
  logic [31:0] data_insert;
  logic [3:0]  keep_insert;
  logic [2:0]  byte_insert_cnt;
  logic [15:0] data_word_cnt;
  logic        hdr_err;

  logic ro_base, tog_en, tog;
  assign ready_out = tog_en ? tog : ro_base;

  axis_insert_header_pipe #(.DATA_WD(32), .CNT_WD(16)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out), .ready_out(ready_out),
    .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
    .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert),
    .data_word_cnt(data_word_cnt), .hdr_err(hdr_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  beat_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Byte-stream model: header bytes (MSB first) then payload bytes, cut into
  // 4-byte output beats with zero padding on the last one.
  task automatic model(input int h, input logic [31:0] hdr, input logic [31:0] p0,
                       input logic [31:0] p1, input int nb, input int lastl);
    byte unsigned q[$];
    beat_t        e;
    logic [31:0]  w;
    int           c;
    for (int i = h - 1; i >= 0; i--) q.push_back(hdr[8*i +: 8]);
    for (int b = 0; b < nb; b++) begin
      w = (b == 0) ? p0 : p1;
      c = (b == nb - 1) ? lastl : 4;
      for (int k = 0; k < c; k++) q.push_back(w[31-8*k -: 8]);
    end
    while (q.size() > 0) begin
      e = '0;
      for (int k = 0; k < 4; k++) begin
        if (q.size() > 0) begin
          e.d[31-8*k -: 8] = q.pop_front();
          e.k[3-k] = 1'b1;
        end
      end
      e.l = (q.size() == 0);
      sb.push_back(e);
    end
  endtask

  task automatic send_hdr(input logic [2:0] h, input logic [31:0] d, input logic [3:0] k);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    valid_insert = 1'b1; data_insert = d; keep_insert = k; byte_insert_cnt = h;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (ready_insert) begin ok = 1'b1; break; end
    end
    if (!ok) chk("hdr_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    valid_insert = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    bit ok;
    ok = 1'b0;
    valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (ready_in) begin ok = 1'b1; break; end
    end
    if (!ok) chk("beat_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    valid_in = 1'b0; last_in = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && sb.size() != 0; t++) @(posedge clk);
    @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  always @(posedge clk) begin
    #1;
    if (tog_en) tog = ~tog;
  end

  // Output monitor
  beat_t       e_mon;
  logic [31:0] m_mon;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [3:0]  prev_keep;
  logic        prev_last;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_data", data_out, prev_data);
        chk("stall_keep", 32'(keep_out), 32'(prev_keep));
        chk("stall_last", 32'(last_out), 32'(prev_last));
        chk("stall_valid", 32'(valid_out), 32'd1);
      end
      if (valid_out && ready_out) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e_mon = sb.pop_front();
          for (int k = 0; k < 4; k++) m_mon[8*k +: 8] = {8{e_mon.k[k]}};
          chk("out_data", data_out & m_mon, e_mon.d);
          chk("out_keep", 32'(keep_out), 32'(e_mon.k));
          chk("out_last", 32'(last_out), 32'(e_mon.l));
        end
      end
      prev_stall = valid_out && !ready_out;
      prev_data  = data_out;
      prev_keep  = keep_out;
      prev_last  = last_out;
    end
  end

  initial begin
    rst = 1'b1; ro_base = 1'b1; tog_en = 1'b0; tog = 1'b1;
    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    valid_insert = 1'b0; data_insert = '0; keep_insert = '0; byte_insert_cnt = '0;

    // Reset state
    @(posedge clk); #1;
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_keep_out", 32'(keep_out), 32'd0);
    chk("rst_last_out", 32'(last_out), 32'd0);
    chk("rst_cnt", 32'(data_word_cnt), 32'd0);
    chk("rst_hdr_err", 32'(hdr_err), 32'd0);
    chk("rst_ready_in", 32'(ready_in), 32'd0);
    chk("rst_ready_insert", 32'(ready_insert), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready_insert", 32'(ready_insert), 32'd1);

    // Case 1: H=2, fits without tail beat
    model(2, 32'h0000AABB, 32'h11223344, 32'h55667788, 2, 2);
    send_hdr(3'd2, 32'h0000AABB, 4'b0011);
    send_beat(32'h11223344, 4'b1111, 1'b0);
    send_beat(32'h55667788, 4'b1100, 1'b1);
    drain();
    chk("c1_cnt", 32'(data_word_cnt), 32'd2);
    chk("c1_hdr_err", 32'(hdr_err), 32'd0);

    // Case 2: overflow, FLUSH tail beat
    model(2, 32'h0000AABB, 32'h11223344, 32'h55667788, 2, 3);
    send_hdr(3'd2, 32'h0000AABB, 4'b0011);
    send_beat(32'h11223344, 4'b1111, 1'b0);
    send_beat(32'h55667788, 4'b1110, 1'b1);
    @(negedge clk);
    chk("c2_flush_ready_in", 32'(ready_in), 32'd0);
    drain();
    chk("c2_cnt", 32'(data_word_cnt), 32'd3);

    // Case 3: H=0 pass-through, latency 1
    model(0, 32'h0, 32'hCAFEF00D, 32'h0, 1, 4);
    send_hdr(3'd0, 32'h0, 4'b0000);
    send_beat(32'hCAFEF00D, 4'b1111, 1'b1);
    chk("c3_lat_valid", 32'(valid_out), 32'd1);
    chk("c3_lat_data", data_out, 32'hCAFEF00D);
    drain();
    chk("c3_cnt", 32'(data_word_cnt), 32'd1);

    // Case 4: H=N, header-only first beat, FLUSH path
    model(4, 32'hDEADBEEF, 32'h01020304, 32'h0, 1, 4);
    send_hdr(3'd4, 32'hDEADBEEF, 4'b1111);
    send_beat(32'h01020304, 4'b1111, 1'b1);
    drain();
    chk("c4_cnt", 32'(data_word_cnt), 32'd2);

    // Clamp: byte_insert_cnt above N behaves as N
    model(4, 32'h0A0B0C0D, 32'h11223344, 32'h0, 1, 2);
    send_hdr(3'd7, 32'h0A0B0C0D, 4'b1111);
    send_beat(32'h11223344, 4'b1100, 1'b1);
    drain();
    chk("clamp_hdr_err", 32'(hdr_err), 32'd0);
    chk("clamp_cnt", 32'(data_word_cnt), 32'd2);

    // Case 5: case 2 under alternating backpressure
    tog_en = 1'b1;
    model(2, 32'h0000AABB, 32'h11223344, 32'h55667788, 2, 3);
    send_hdr(3'd2, 32'h0000AABB, 4'b0011);
    send_beat(32'h11223344, 4'b1111, 1'b0);
    send_beat(32'h55667788, 4'b1110, 1'b1);
    drain();
    tog_en = 1'b0;
    chk("c5_cnt", 32'(data_word_cnt), 32'd3);

    // Case 6: header keep mismatch, then reset mid-STREAM
    send_hdr(3'd2, 32'h0000AABB, 4'b0101);
    chk("c6_hdr_err_set", 32'(hdr_err), 32'd1);
    sb.push_back({32'hAABB1122, 4'b1111, 1'b0});
    send_beat(32'h11223344, 4'b1111, 1'b0);
    send_beat(32'h55667788, 4'b1111, 1'b0);
    ro_base = 1'b0;
    @(negedge clk);
    chk("c6_hdr_err_sticky", 32'(hdr_err), 32'd1);
    chk("c6_pre_valid", 32'(valid_out), 32'd1);
    chk("c6_pre_cnt", 32'(data_word_cnt), 32'd1);
    rst = 1'b1;
    #1;
    chk("c6_rst_valid", 32'(valid_out), 32'd0);
    chk("c6_rst_cnt", 32'(data_word_cnt), 32'd0);
    chk("c6_rst_hdr_err", 32'(hdr_err), 32'd0);
    chk("c6_rst_ready_insert", 32'(ready_insert), 32'd0);
    #3;
    rst = 1'b0;
    ro_base = 1'b1;
    model(2, 32'h0000AABB, 32'h11223344, 32'h55667788, 2, 2);
    send_hdr(3'd2, 32'h0000AABB, 4'b0011);
    send_beat(32'h11223344, 4'b1111, 1'b0);
    send_beat(32'h55667788, 4'b1100, 1'b1);
    drain();
    chk("c6_clean_cnt", 32'(data_word_cnt), 32'd2);
    chk("c6_clean_hdr_err", 32'(hdr_err), 32'd0);

    repeat (3) @(posedge clk);
    chk("sb_final_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
